// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: datapath width, default boot address
// and the {pc, inst} entry carried between fetch and decode.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst} entries between memory return and decode.
module fetch_buf
    import rv32i_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a synchronous-read instruction memory,
// buffers returned words and hands them to decode with valid/ready.
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     MEM_WORDS = 'h6000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            oob_flagged;
    logic            err_q;

    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            buf_full;
    logic            buf_empty;
    logic [1:0]      buf_count;

    logic            pop;
    logic            buf_pop;
    logic            push;
    logic            oob;
    logic            issue;
    logic [2:0]      occ;

    assign mem_addr  = pc;
    assign fetch_err = err_q;

    assign oob = ({2'b00, pc[XLEN-1:2]} >= XLEN'(MEM_WORDS));

    // An empty buffer lets the returning word go straight to decode, which
    // is what gives first-instruction-one-cycle-after-address latency.
    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        if (!buf_empty) begin
            inst_valid = 1'b1;
            inst       = head.inst;
            inst_pc    = head.pc;
        end else if (inflight) begin
            inst_valid = 1'b1;
            inst       = mem_rdata;
            inst_pc    = inflight_pc;
        end
    end

    assign pop        = inst_valid && inst_ready;
    assign buf_pop    = pop && !buf_empty;
    assign push_entry = '{pc: inflight_pc, inst: mem_rdata};
    assign push       = inflight && !redirect_valid && !(buf_empty && inst_ready)
                        && (!buf_full || buf_pop);

    // Issue only if every word already owed to us still has a slot next cycle.
    assign occ   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = !oob && (occ <= 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            oob_flagged <= 1'b0;
            err_q       <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= align_word(redirect_pc);
            inflight    <= 1'b0;
            oob_flagged <= 1'b0;
            err_q       <= (redirect_pc[1:0] != 2'b00);
        end else begin
            err_q <= oob && !oob_flagged;
            if (oob) begin
                oob_flagged <= 1'b1;
            end
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

endmodule
